// File: rtl/mux_2to1_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : mux_2to1_arbiter_if
//  Description : Handshake bundle for the 2-to-1 arbiter: two valid/ready
//                requesters (A, B), one valid/ready output channel, plus the
//                mux select and busy status.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mux_2to1_arbiter_if #(
    parameter int DATA_W = 8
);
    logic              a_valid;
    logic [DATA_W-1:0] a_data;
    logic              a_ready;
    logic              b_valid;
    logic [DATA_W-1:0] b_data;
    logic              b_ready;
    logic              y_valid;
    logic [DATA_W-1:0] y_data;
    logic              y_ready;
    logic              sel;
    logic              busy;

    // Arbiter side: consumes requests, produces the output channel.
    modport slave (
        input  a_valid, a_data,
        output a_ready,
        input  b_valid, b_data,
        output b_ready,
        output y_valid, y_data,
        input  y_ready,
        output sel, busy
    );

    // Requester/consumer side.
    modport master (
        output a_valid, a_data,
        input  a_ready,
        output b_valid, b_data,
        input  b_ready,
        input  y_valid, y_data,
        output y_ready,
        input  sel, busy
    );
endinterface
`default_nettype wire

// File: rtl/mux_2to1_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mux_2to1_arbiter
//  Description : Round-robin arbiter and sequencer for a 2-to-1 mux datapath.
//                Grants one of two valid/ready requesters at a time, limits a
//                grant to MAX_BURST transfers while the other side waits, and
//                registers the selected word into a one-entry output stage.
//  Revision    : 1.0 - initial release
// ============================================================================
module mux_2to1_arbiter #(
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 4     // 1..255
) (
    input  logic               clk,
    input  logic               rst_n,
    mux_2to1_arbiter_if.slave  bus
);

    localparam int          c_CNT_W      = 8;
    localparam logic [1:0]  c_ST_IDLE    = 2'd0;
    localparam logic [1:0]  c_ST_GNT_A   = 2'd1;
    localparam logic [1:0]  c_ST_GNT_B   = 2'd2;
    // Counter value at which the current transfer is the last one of a burst.
    localparam logic [c_CNT_W-1:0] c_BURST_LAST = c_CNT_W'(MAX_BURST - 1);

    logic [1:0]         r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_sel;
    logic               r_last_b;      // 1 = B was served last
    logic               r_y_valid;
    logic [DATA_W-1:0]  r_y_data;

    logic [1:0]         w_nxt_state;
    logic [c_CNT_W-1:0] w_nxt_cnt;
    logic               w_can_load;
    logic               w_a_ready;
    logic               w_b_ready;
    logic               w_xfer_a;
    logic               w_xfer_b;
    logic               w_xfer;
    logic               w_cur_valid;
    logic               w_oth_valid;
    logic [1:0]         w_oth_state;
    logic               w_burst_last;

    // Handshake decode: a grantee may only move data when the output stage
    // is empty or being drained in the same cycle.
    assign w_can_load   = !r_y_valid || bus.y_ready;
    assign w_a_ready    = (r_state == c_ST_GNT_A) && w_can_load;
    assign w_b_ready    = (r_state == c_ST_GNT_B) && w_can_load;
    assign w_xfer_a     = bus.a_valid && w_a_ready;
    assign w_xfer_b     = bus.b_valid && w_b_ready;
    assign w_xfer       = w_xfer_a || w_xfer_b;
    assign w_cur_valid  = (r_state == c_ST_GNT_B) ? bus.b_valid : bus.a_valid;
    assign w_oth_valid  = (r_state == c_ST_GNT_B) ? bus.a_valid : bus.b_valid;
    assign w_oth_state  = (r_state == c_ST_GNT_B) ? c_ST_GNT_A : c_ST_GNT_B;
    assign w_burst_last = (r_cnt == c_BURST_LAST);

    // Next-state and burst-counter decision; the first matching rule wins.
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_cnt   = r_cnt;
        case (r_state)
            c_ST_IDLE: begin
                w_nxt_cnt = '0;
                if (bus.a_valid && bus.b_valid) begin
                    w_nxt_state = r_last_b ? c_ST_GNT_A : c_ST_GNT_B;
                end else if (bus.a_valid) begin
                    w_nxt_state = c_ST_GNT_A;
                end else if (bus.b_valid) begin
                    w_nxt_state = c_ST_GNT_B;
                end
            end
            c_ST_GNT_A, c_ST_GNT_B: begin
                if (w_xfer && w_burst_last && w_oth_valid) begin
                    w_nxt_state = w_oth_state;
                    w_nxt_cnt   = '0;
                end else if (!w_cur_valid && w_oth_valid) begin
                    w_nxt_state = w_oth_state;
                    w_nxt_cnt   = '0;
                end else if (!w_cur_valid) begin
                    w_nxt_state = c_ST_IDLE;
                    w_nxt_cnt   = '0;
                end else if (w_xfer && !w_burst_last) begin
                    // Saturates at the burst limit while the other side idles.
                    w_nxt_cnt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_nxt_state = c_ST_IDLE;
                w_nxt_cnt   = '0;
            end
        endcase
    end

    // Grant state, burst counter, registered select and round-robin history.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= c_ST_IDLE;
            r_cnt    <= '0;
            r_sel    <= 1'b0;
            r_last_b <= 1'b1;
        end else begin
            r_state <= w_nxt_state;
            r_cnt   <= w_nxt_cnt;
            if (w_nxt_state == c_ST_GNT_A) begin
                r_sel <= 1'b0;
            end else if (w_nxt_state == c_ST_GNT_B) begin
                r_sel <= 1'b1;
            end
            if (w_xfer) begin
                r_last_b <= w_xfer_b;
            end
        end
    end

    // One-entry output stage: load on transfer, clear on drain without load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_y_valid <= 1'b0;
            r_y_data  <= '0;
        end else if (w_xfer) begin
            r_y_valid <= 1'b1;
            r_y_data  <= w_xfer_b ? bus.b_data : bus.a_data;
        end else if (bus.y_ready) begin
            r_y_valid <= 1'b0;
        end
    end

    assign bus.a_ready = w_a_ready;
    assign bus.b_ready = w_b_ready;
    assign bus.y_valid = r_y_valid;
    assign bus.y_data  = r_y_data;
    assign bus.sel     = r_sel;
    assign bus.busy    = (r_state != c_ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mux_2to1_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mux_2to1_arbiter
//  Description : Directed self-checking bench for mux_2to1_arbiter, using a
//                MAX_BURST=4 instance and a MAX_BURST=1 instance.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mux_2to1_arbiter;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    mux_2to1_arbiter_if #(.DATA_W(8)) bus4 ();
    mux_2to1_arbiter_if #(.DATA_W(8)) bus1 ();

    mux_2to1_arbiter #(.DATA_W(8), .MAX_BURST(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4)
    );

    mux_2to1_arbiter #(.DATA_W(8), .MAX_BURST(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    // Expected output words / selects after edges E2..E13 (burst of 4).
    logic [7:0] exp_y4   [12] = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hB0, 8'hB1,
                                  8'hB2, 8'hB3, 8'hA4, 8'hA5, 8'hA6, 8'hA7};
    logic       exp_sel4 [12] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1,
                                  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    // Expected after edges E2..E9 (burst of 1: strict alternation).
    logic [7:0] exp_y1   [8]  = '{8'hC0, 8'hD0, 8'hC1, 8'hD1,
                                  8'hC2, 8'hD2, 8'hC3, 8'hD3};
    logic       exp_sel1 [8]  = '{1'b1, 1'b0, 1'b1, 1'b0,
                                  1'b1, 1'b0, 1'b1, 1'b0};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus4.a_valid = 1'b0; bus4.a_data = 8'h00;
        bus4.b_valid = 1'b0; bus4.b_data = 8'h00;
        bus4.y_ready = 1'b1;
        bus1.a_valid = 1'b0; bus1.a_data = 8'h00;
        bus1.b_valid = 1'b0; bus1.b_data = 8'h00;
        bus1.y_ready = 1'b1;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        logic ra;
        logic rb;
        int   ia;
        int   ib;
        checks = 0;
        errors = 0;

        // ---- Reset values ------------------------------------------------
        rst_n = 1'b0;
        bus4.a_valid = 1'b0; bus4.a_data = 8'h00;
        bus4.b_valid = 1'b0; bus4.b_data = 8'h00;
        bus4.y_ready = 1'b1;
        bus1.a_valid = 1'b0; bus1.a_data = 8'h00;
        bus1.b_valid = 1'b0; bus1.b_data = 8'h00;
        bus1.y_ready = 1'b1;
        #3;
        check("rst_y_valid", bus4.y_valid, 0);
        check("rst_y_data",  bus4.y_data,  0);
        check("rst_sel",     bus4.sel,     0);
        check("rst_busy",    bus4.busy,    0);
        check("rst_a_ready", bus4.a_ready, 0);
        check("rst_b_ready", bus4.b_ready, 0);
        tick();
        rst_n = 1'b1;

        // ---- Single requester A, saturating burst counter -----------------
        bus4.a_valid = 1'b1; bus4.a_data = 8'h11;
        tick();
        check("t1_busy_gnt",  bus4.busy,    1);
        check("t1_sel_gnt",   bus4.sel,     0);
        check("t1_a_ready",   bus4.a_ready, 1);
        check("t1_y_empty",   bus4.y_valid, 0);
        tick();
        check("t1_y_11",      bus4.y_data,  8'h11);
        check("t1_yv_11",     bus4.y_valid, 1);
        check("t1_a_ready2",  bus4.a_ready, 1);
        bus4.a_data = 8'h12;
        tick();
        check("t1_y_12",      bus4.y_data,  8'h12);
        bus4.a_data = 8'h13;
        tick();
        check("t1_y_13",      bus4.y_data,  8'h13);
        check("t1_cnt_3",     dut4.r_cnt,   3);
        bus4.a_data = 8'h14;
        tick();
        check("t1_y_14",      bus4.y_data,  8'h14);
        check("t1_sel_hold",  bus4.sel,     0);
        check("t1_a_rdy_sat", bus4.a_ready, 1);
        check("t1_cnt_sat",   dut4.r_cnt,   3);
        bus4.a_valid = 1'b0;
        tick();
        check("t1_idle_busy", bus4.busy,    0);
        check("t1_drain",     bus4.y_valid, 0);
        check("t1_idle_sel",  bus4.sel,     0);

        // ---- Both valid, burst of 4 round-robin --------------------------
        do_reset();
        bus4.a_valid = 1'b1; bus4.a_data = 8'hA0;
        bus4.b_valid = 1'b1; bus4.b_data = 8'hB0;
        ia = 0; ib = 0;
        tick();
        for (int i = 0; i < 12; i++) begin
            ra = bus4.a_ready;
            rb = bus4.b_ready;
            tick();
            check($sformatf("t2_y_%0d", i),   bus4.y_data,  exp_y4[i]);
            check($sformatf("t2_yv_%0d", i),  bus4.y_valid, 1);
            check($sformatf("t2_sel_%0d", i), bus4.sel,     exp_sel4[i]);
            if (ra) begin ia++; bus4.a_data = 8'hA0 + 8'(ia); end
            if (rb) begin ib++; bus4.b_data = 8'hB0 + 8'(ib); end
        end

        // ---- A drops after 2 transfers, B takes over ---------------------
        do_reset();
        bus4.a_valid = 1'b1; bus4.a_data = 8'h21;
        bus4.b_valid = 1'b1; bus4.b_data = 8'h31;
        tick();
        tick();
        check("t3_y_21", bus4.y_data, 8'h21);
        bus4.a_data = 8'h22;
        tick();
        check("t3_y_22", bus4.y_data, 8'h22);
        bus4.a_valid = 1'b0;
        tick();
        check("t3_sel_b",    bus4.sel,     1);
        check("t3_b_ready",  bus4.b_ready, 1);
        check("t3_a_ready",  bus4.a_ready, 0);
        check("t3_y_drain",  bus4.y_valid, 0);
        check("t3_cnt_0",    dut4.r_cnt,   0);
        tick();
        check("t3_y_31",     bus4.y_data,  8'h31);
        check("t3_yv_31",    bus4.y_valid, 1);
        bus4.b_data = 8'h5A;

        // ---- Output stall ------------------------------------------------
        tick();
        check("t4_y_5a", bus4.y_data, 8'h5A);
        bus4.y_ready = 1'b0;
        bus4.b_data  = 8'h5B;
        #1;
        check("t4_b_rdy_stall", bus4.b_ready, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("t4_hold_y_%0d", i),  bus4.y_data,  8'h5A);
            check($sformatf("t4_hold_yv_%0d", i), bus4.y_valid, 1);
            check($sformatf("t4_hold_br_%0d", i), bus4.b_ready, 0);
            check($sformatf("t4_hold_ar_%0d", i), bus4.a_ready, 0);
            check($sformatf("t4_hold_sel_%0d", i), bus4.sel,    1);
        end
        bus4.y_ready = 1'b1;
        #1;
        check("t4_b_rdy_resume", bus4.b_ready, 1);
        tick();
        check("t4_y_5b", bus4.y_data, 8'h5B);
        bus4.b_data = 8'h5C;
        tick();
        check("t4_y_5c",   bus4.y_data, 8'h5C);
        check("t4_sel_b",  bus4.sel,    1);

        // ---- Asynchronous reset mid-burst in GNT_B -----------------------
        bus4.a_valid = 1'b1; bus4.a_data = 8'h61;
        #1;
        rst_n = 1'b0;
        #1;
        check("t5_y_valid", bus4.y_valid, 0);
        check("t5_y_data",  bus4.y_data,  0);
        check("t5_sel",     bus4.sel,     0);
        check("t5_busy",    bus4.busy,    0);
        check("t5_b_ready", bus4.b_ready, 0);
        #2;
        rst_n = 1'b1;
        tick();
        check("t5_gnt_a_sel", bus4.sel,     0);
        check("t5_gnt_a_rdy", bus4.a_ready, 1);
        check("t5_gnt_b_rdy", bus4.b_ready, 0);
        check("t5_gnt_busy",  bus4.busy,    1);
        tick();
        check("t5_y_61", bus4.y_data, 8'h61);

        // ---- MAX_BURST=1 strict alternation ------------------------------
        do_reset();
        bus1.a_valid = 1'b1; bus1.a_data = 8'hC0;
        bus1.b_valid = 1'b1; bus1.b_data = 8'hD0;
        ia = 0; ib = 0;
        tick();
        for (int i = 0; i < 8; i++) begin
            ra = bus1.a_ready;
            rb = bus1.b_ready;
            tick();
            check($sformatf("t6_y_%0d", i),   bus1.y_data,  exp_y1[i]);
            check($sformatf("t6_yv_%0d", i),  bus1.y_valid, 1);
            check($sformatf("t6_sel_%0d", i), bus1.sel,     exp_sel1[i]);
            if (ra) begin ia++; bus1.a_data = 8'hC0 + 8'(ia); end
            if (rb) begin ib++; bus1.b_data = 8'hD0 + 8'(ib); end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mux_2to1_arbiter.md
Name: mux_2to1_arbiter

Overview:
- Round-robin arbiter and sequencer for the 2-to-1 multiplexer datapath.
- Shares one output channel between two valid/ready requesters (A, B) and drives the mux select.
- Registers the selected data into a one-entry output stage.
- Sits in front of any consumer that previously took a hard-wired select line.

Parameters:
- DATA_W, 8, width of requester and output data.
- MAX_BURST, 4, max consecutive transfers granted to one requester while the other is waiting; range 1..255.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- a_valid  input  1  requester A has data.
- a_data  input  DATA_W  requester A data.
- a_ready  output  1  A transfer accepted this cycle.
- b_valid  input  1  requester B has data.
- b_data  input  DATA_W  requester B data.
- b_ready  output  1  B transfer accepted this cycle.
- y_valid  output  1  output stage holds data.
- y_data  output  DATA_W  output data.
- y_ready  input  1  consumer accepts y_data.
- sel  output  1  current mux select: 0 = A, 1 = B.
- busy  output  1  high when state is not IDLE.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values:
  - State IDLE; sel=0; y_valid=0; y_data=0; a_ready=0; b_ready=0; busy=0.
  - Burst counter = 0.
  - last_served = B, so A wins the first tie.
- FSM states: IDLE, GNT_A, GNT_B.
- IDLE:
  - a_valid & b_valid: go to the requester not equal to last_served.
  - Else go to whichever is valid.
  - Neither valid: stay.
  - Always one cycle of grant latency from IDLE; no transfer happens in IDLE.
- Output stage:
  - can_load = !y_valid | y_ready.
  - a_ready = (state==GNT_A) & can_load. b_ready = (state==GNT_B) & can_load. Both are combinational outputs.
- Transfer:
  - A transfer occurs when x_valid & x_ready.
  - At the clock edge: y_data <= x_data, y_valid <= 1, counter++, last_served <= x.
- Output drain: y_valid clears on y_ready with no new load in the same cycle. Simultaneous drain and load keeps y_valid=1 with new data, giving full throughput of 1 word/cycle.
- sel: registered. Equals 0 in GNT_A and 1 in GNT_B. Holds its last value in IDLE.
- GNT_x transitions, evaluated each cycle, first match wins:
  1. Transfer occurs and counter+1 == MAX_BURST and other_valid: switch to GNT_other, counter=0.
  2. x_valid=0 and other_valid: switch to GNT_other, counter=0.
  3. x_valid=0 and !other_valid: go to IDLE, counter=0.
  4. Otherwise stay. Counter saturates at MAX_BURST-1 while the other side is idle; it never wraps to 0 without a switch.
- Stall: when can_load=0, a requester with x_valid=1 keeps the grant. The stall does not count toward the burst.
- Switch: no bubble on a GNT_A to GNT_B switch. The new grantee may transfer in the first cycle of its grant.
- Protocol: a requester must hold x_valid and x_data stable until x_ready. The block does not check this.
- Output hold: y_data/y_valid hold stable while y_valid & !y_ready.
- Reset mid-operation: all state returns to reset values immediately (asynchronous); any word in the output stage is dropped. First grant after reset release follows IDLE rules.
- MAX_BURST=1: strict alternation whenever both sides are valid.

Test Plan:
1. Reset with y_ready=1; a_valid=1, a_data=0x11..0x13 sequence, b_valid=0 → IDLE one cycle, then GNT_A, sel=0. y_data shows 0x11, 0x12, 0x13 on consecutive cycles; a_ready never drops; counter saturates with no switch.
2. a_valid=b_valid=1 continuously, MAX_BURST=4, y_ready=1 → output order A,A,A,A,B,B,B,B,A... First grant goes to A (tie after reset); sel toggles every 4 transfers with no idle cycles.
3. In GNT_A with b_valid=1, a_valid deasserts after 2 transfers → next cycle GNT_B, counter=0, b_data appears on y_data one cycle after b_ready.
4. y_ready=0 for 5 cycles with y_valid=1, y_data=0x5A → y_data stays 0x5A, a_ready=b_ready=0, state unchanged. On y_ready=1 the stream resumes with no loss or duplication.
5. rst_n pulsed low mid-burst in GNT_B with y_valid=1 → asynchronously y_valid=0, sel=0, busy=0. After release with both valid, A is granted first.
6. MAX_BURST=1 build, both always valid → output strictly A,B,A,B; each a_data/b_data word is seen exactly once.
